mano_seq_ctrl: RTL and testbench

Parametrised timing and control-sequencing block for the Mano basic computer datapath. It holds the sequence counter (SC), decodes it into one-hot timing signals T0..T(N-1), and latches the opcode and indirect bit from the instruction register into one-hot D0..D(2^OP_W-1). It also tracks the fetch/decode/execute/interrupt phase, including the optional interrupt flip-flop R. It sits between the instruction register and the control-logic gates, replacing the fixed five-state T0–T4 / IR-bit decoder.

---
 rtl/mano_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mano_seq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl -- timing and control sequencer for the Mano basic computer.
//
// Holds the sequence counter SC and decodes it into one-hot timing signals,
// latches the opcode and indirect bit from the instruction register and
// decodes the opcode one-hot, and reports which instruction phase the
// machine is in.
//
// Optional feature macro: MANO_INTR_EN
//   defined   -> interrupt-cycle flip-flop R, INTR phase and intr_ack built
//   undefined -> r_flag/intr_ack stay 0, ien/irq ignored, phase never INTR
//
// Parameters
//   SC_W      sequence counter width
//   T_STATES  number of timing states (4 .. 2**SC_W); SC counts modulo this
//   OP_W      opcode width; d_onehot is 2**OP_W wide
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   sc_en, sc_clr   increment / clear SC (clear wins)
//   ir_ld, ir_in    latch {I, opcode} from the instruction register
//   ien, irq        interrupt enable and request (level)
//   t_onehot        bit k high when SC == k
//   d_onehot        bit k high when latched opcode == k
//   i_bit           latched indirect bit
//   sc_val          current SC value
//   phase           0 FETCH, 1 DECODE, 2 EXEC, 3 INTR
//   r_flag          interrupt-cycle flip-flop R
//   intr_ack        one-cycle pulse after the interrupt cycle completes
//   sc_ovf          sticky: SC wrapped past T_STATES-1
module mano_seq_ctrl #(
  parameter int SC_W     = 4,
  parameter int T_STATES = 16,
  parameter int OP_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sc_en,
  input  logic                   sc_clr,
  input  logic                   ir_ld,
  input  logic [OP_W:0]          ir_in,
  input  logic                   ien,
  input  logic                   irq,
  output logic [T_STATES-1:0]    t_onehot,
  output logic [(1<<OP_W)-1:0]   d_onehot,
  output logic                   i_bit,
  output logic [SC_W-1:0]        sc_val,
  output logic [1:0]             phase,
  output logic                   r_flag,
  output logic                   intr_ack,
  output logic                   sc_ovf
);

  localparam int D_W = 1 << OP_W;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(T_STATES - 1);
  localparam logic [SC_W-1:0] SC_T1   = SC_W'(1);
  localparam logic [SC_W-1:0] SC_T2   = SC_W'(2);
  localparam logic [SC_W-1:0] SC_T3   = SC_W'(3);

  typedef enum logic [1:0] {
    PH_FETCH  = 2'd0,
    PH_DECODE = 2'd1,
    PH_EXEC   = 2'd2,
    PH_INTR   = 2'd3
  } phase_t;

  logic [SC_W-1:0] sc_reg, sc_next;
  logic [OP_W-1:0] op_reg;
  logic            i_reg;
  logic            r_reg, r_next;
  logic            ack_reg, ack_next;
  logic            ovf_reg, ovf_next;
  logic            intr_done;
  logic            r_set;
  phase_t          phase_cur;

`ifdef MANO_INTR_EN
  // The interrupt cycle is T0..T2; advancing out of T2 ends it.
  assign intr_done = r_reg && (sc_reg == SC_T2) && sc_en;
  // Only armed during execute (T3 and later) so the current instruction's
  // own sc_clr still lands before the interrupt cycle starts at T0.
  assign r_set     = !r_reg && (sc_reg >= SC_T3) && ien && irq && sc_en;
`else
  logic unused_intr_inputs;
  assign unused_intr_inputs = ien ^ irq;
  assign intr_done = 1'b0;
  assign r_set     = 1'b0;
`endif

  always_comb begin
    sc_next  = sc_reg;
    ovf_next = ovf_reg;
    r_next   = r_reg;
    ack_next = intr_done;

    if (intr_done) begin
      sc_next = '0;
    end else if (sc_clr) begin
      sc_next = '0;
    end else if (sc_en && (sc_reg == SC_LAST)) begin
      // Wrap is modulo T_STATES, not the natural 2**SC_W roll-over.
      sc_next  = '0;
      ovf_next = 1'b1;
    end else if (sc_en) begin
      sc_next = sc_reg + 1'b1;
    end

    // Set and completion are mutually exclusive (sc >= 3 vs sc == 2).
    if (r_set) begin
      r_next = 1'b1;
    end else if (intr_done) begin
      r_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_reg  <= '0;
      op_reg  <= '0;
      i_reg   <= 1'b0;
      r_reg   <= 1'b0;
      ack_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      sc_reg  <= sc_next;
      r_reg   <= r_next;
      ack_reg <= ack_next;
      ovf_reg <= ovf_next;
      if (ir_ld) begin
        op_reg <= ir_in[OP_W-1:0];
        i_reg  <= ir_in[OP_W];
      end
    end
  end

  always_comb begin
    phase_cur = PH_EXEC;
    if (r_reg) begin
      phase_cur = PH_INTR;
    end else if (sc_reg <= SC_T1) begin
      phase_cur = PH_FETCH;
    end else if (sc_reg == SC_T2) begin
      phase_cur = PH_DECODE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < T_STATES; gi++) begin : g_t_dec
      assign t_onehot[gi] = (sc_reg == SC_W'(gi));
    end
    for (gi = 0; gi < D_W; gi++) begin : g_d_dec
      assign d_onehot[gi] = (op_reg == OP_W'(gi));
    end
  endgenerate

  assign i_bit    = i_reg;
  assign sc_val   = sc_reg;
  assign phase    = phase_cur;
  assign r_flag   = r_reg;
  assign intr_ack = ack_reg;
  assign sc_ovf   = ovf_reg;

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb_mano_seq_ctrl -- directed plus randomized bench for mano_seq_ctrl.
// A cycle-level reference model holds SC, opcode, I, R, the ack pulse and
// the overflow flag as plain integers; every output is compared each cycle.
module tb_mano_seq_ctrl;

  localparam int SC_W     = 4;
  localparam int T_STATES = 16;
  localparam int OP_W     = 3;
  localparam int D_W      = 1 << OP_W;

`ifdef MANO_INTR_EN
  localparam bit INTR_ON = 1'b1;
`else
  localparam bit INTR_ON = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                sc_en;
  logic                sc_clr;
  logic                ir_ld;
  logic [OP_W:0]       ir_in;
  logic                ien;
  logic                irq;
  logic [T_STATES-1:0] t_onehot;
  logic [D_W-1:0]      d_onehot;
  logic                i_bit;
  logic [SC_W-1:0]     sc_val;
  logic [1:0]          phase;
  logic                r_flag;
  logic                intr_ack;
  logic                sc_ovf;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_sc, m_op, m_i, m_r, m_ack, m_ovf;

  mano_seq_ctrl #(.SC_W(SC_W), .T_STATES(T_STATES), .OP_W(OP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sc_en    (sc_en),
    .sc_clr   (sc_clr),
    .ir_ld    (ir_ld),
    .ir_in    (ir_in),
    .ien      (ien),
    .irq      (irq),
    .t_onehot (t_onehot),
    .d_onehot (d_onehot),
    .i_bit    (i_bit),
    .sc_val   (sc_val),
    .phase    (phase),
    .r_flag   (r_flag),
    .intr_ack (intr_ack),
    .sc_ovf   (sc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_sc = 0; m_op = 0; m_i = 0; m_r = 0; m_ack = 0; m_ovf = 0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_phase;
    if (m_r != 0)      exp_phase = 3;
    else if (m_sc < 2) exp_phase = 0;
    else if (m_sc == 2) exp_phase = 1;
    else               exp_phase = 2;
    $display("[%0t] %s sc=%0d t=%h d=%h i=%0d ph=%0d r=%0d ack=%0d ovf=%0d",
             $time, tag, sc_val, t_onehot, d_onehot, i_bit, phase, r_flag, intr_ack, sc_ovf);
    cmp({tag, ".sc"},    32'(sc_val),   32'(m_sc));
    cmp({tag, ".t"},     32'(t_onehot), 32'(1) << m_sc);
    cmp({tag, ".d"},     32'(d_onehot), 32'(1) << m_op);
    cmp({tag, ".i"},     32'(i_bit),    32'(m_i));
    cmp({tag, ".phase"}, 32'(phase),    32'(exp_phase));
    cmp({tag, ".r"},     32'(r_flag),   32'(m_r));
    cmp({tag, ".ack"},   32'(intr_ack), 32'(m_ack));
    cmp({tag, ".ovf"},   32'(sc_ovf),   32'(m_ovf));
  endtask

  // Drive one cycle's inputs, clock it, advance the model, check outputs.
  task automatic cyc(input string tag, input bit en, input bit clr, input bit ld,
                     input int ir, input bit ie, input bit iq);
    bit done, setr;
    sc_en = en; sc_clr = clr; ir_ld = ld; ir_in = (OP_W+1)'(ir); ien = ie; irq = iq;
    @(posedge clk);
    done = INTR_ON && (m_r == 1) && (m_sc == 2) && en;
    setr = INTR_ON && (m_r == 0) && (m_sc >= 3) && ie && iq && en;
    if (done || clr) begin
      m_sc = 0;
    end else if (en) begin
      if (m_sc + 1 >= T_STATES) m_ovf = 1;
      m_sc = (m_sc + 1) % T_STATES;
    end
    m_ack = done ? 1 : 0;
    if (setr) m_r = 1;
    else if (done) m_r = 0;
    if (ld) begin
      m_op = ir % D_W;
      m_i  = (ir >> OP_W) & 1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; sc_en = 0; sc_clr = 0; ir_ld = 0; ir_in = '0; ien = 0; irq = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    rst = 1'b0;

    // count to 7 with an opcode latched, then reset asynchronously
    cyc("pre_ld", 1, 0, 1, 4'b1110, 0, 0);
    for (int k = 0; k < 6; k++) cyc("pre_cnt", 1, 0, 0, 0, 0, 0);
    cmp("pre_sc7", 32'(sc_val), 32'd7);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_held");
    rst = 1'b0;

    // count/decode from reset
    for (int k = 0; k < 5; k++) cyc("count", 1, 0, 0, 0, 0, 0);
    cmp("t5_set", 32'(t_onehot[5]), 32'd1);
    cyc("ir_ld", 0, 0, 1, 4'b1101, 0, 0);
    cmp("d_20", 32'(d_onehot), 32'h20);

    // priority: sc=6, clear and enable together
    cyc("to6", 1, 0, 0, 0, 0, 0);
    cmp("sc6", 32'(sc_val), 32'd6);
    cyc("clr_en", 1, 1, 0, 0, 0, 0);
    cyc("hold_a", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("hold", 0, 0, 0, 0, 0, 0);

    // wrap: from 0, 16 increments, then a clear must not drop sc_ovf
    cyc("clr", 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < T_STATES; k++) cyc("wrap", 1, 0, 0, 0, 0, 0);
    cmp("ovf_set", 32'(sc_ovf), 32'd1);
    cyc("ovf_clr", 0, 1, 0, 0, 0, 0);

    // interrupt sequence
    for (int k = 0; k < 3; k++) cyc("to_t3", 1, 0, 0, 0, 0, 0);
    cyc("r_set", 1, 0, 0, 0, 1, 1);
    cyc("instr_end", 0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) cyc("intr_cyc", 1, 0, 0, 0, 0, 0);
    cyc("ack_drop", 0, 0, 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc("rand",
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
